// File: rtl/vfx_stream_pkg.sv
// Shared types for the video-effects stream controllers.
//   state_t      : frame tracking state (IDLE between frames, RUN inside one)
//   freq_level_t : 2-bit audio frequency level driven to the inversion stage
//   FRAME_PIXELS_DEFAULT : accepted beats per 320x240 frame, sop through eop
package vfx_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int FRAME_PIXELS_DEFAULT = 76800;

    typedef logic [1:0] freq_level_t;

endpackage

// File: rtl/freq_hysteresis.sv
// Frame-count hysteresis for the audio frequency level.
// Tracks a candidate level and how many consecutive ticks (frame starts) it
// has been seen, saturating at 15. On a tick the combinational outputs tell
// the caller whether the updated candidate is stable enough to commit.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   tick          : one-cycle strobe, an accepted start-of-frame beat
//   freq_req      : live frequency level sampled on tick
//   commit_ok     : updated stable count >= HOLD_FRAMES (valid on tick)
//   commit_level  : updated candidate level (valid on tick)
module freq_hysteresis
    import vfx_stream_pkg::*;
#(
    parameter int HOLD_FRAMES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  freq_level_t freq_req,
    output logic        commit_ok,
    output freq_level_t commit_level
);

    freq_level_t candidate_q;
    logic [3:0]  stable_q;
    logic [3:0]  stable_d;

    // The "updated" values are what the counters become on this tick; the
    // commit decision is made on them so a level can commit on the very
    // tick that makes it stable.
    always_comb begin
        commit_level = candidate_q;
        stable_d     = stable_q;
        if (freq_req == candidate_q) begin
            stable_d = (stable_q == 4'd15) ? 4'd15 : stable_q + 4'd1;
        end else begin
            commit_level = freq_req;
            stable_d     = 4'd1;
        end
        commit_ok = (stable_d >= 4'(HOLD_FRAMES));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            candidate_q <= '0;
            stable_q    <= '0;
        end else if (tick) begin
            candidate_q <= commit_level;
            stable_q    <= stable_d;
        end
    end

endmodule

// File: rtl/inversion_scheduler.sv
// Frame-synchronous controller for the pixel inversion stage.
// Monitors the stream sideband (sop/eop/valid/ready), commits the requested
// enable and the debounced frequency level only on accepted start-of-frame
// beats, and flags frames whose accepted length is wrong.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   enable_req    : user filter enable, asynchronous to frames
//   freq_req      : live frequency level from the audio path
//   sop_in/eop_in : stream start/end of packet (monitored only)
//   valid_in      : stream valid; ready_in : downstream ready
//   use_flag      : committed enable to the inversion stage
//   freq_flag     : committed frequency level to the inversion stage
//   in_frame      : high while a frame is open
//   frame_err     : one-cycle pulse on a frame length error
//   frame_count   : good frames seen, wraps modulo 256
// Handshake: a beat exists only when valid_in && ready_in in the same cycle;
// sop/eop on any other cycle are ignored.
module inversion_scheduler
    import vfx_stream_pkg::*;
#(
    parameter int HOLD_FRAMES  = 3,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_req,
    input  freq_level_t freq_req,
    input  logic        sop_in,
    input  logic        eop_in,
    input  logic        valid_in,
    input  logic        ready_in,
    output logic        use_flag,
    output freq_level_t freq_flag,
    output logic        in_frame,
    output logic        frame_err,
    output logic [7:0]  frame_count
);

    localparam logic [CNT_W-1:0] LEN_GOOD = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] LEN_OVER = CNT_W'(FRAME_PIXELS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic acc, sop_acc, eop_acc;
    assign acc     = valid_in && ready_in;
    assign sop_acc = acc && sop_in;
    assign eop_acc = acc && eop_in;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_d, good_d;
    logic             commit_ok;
    freq_level_t      commit_level;

    freq_hysteresis #(
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_hyst (
        .clk          (clk),
        .reset        (reset),
        .tick         (sop_acc),
        .freq_req     (freq_req),
        .commit_ok    (commit_ok),
        .commit_level (commit_level)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

    // Next-state, pixel count and frame verdict. A beat carrying both sop
    // and eop opens and closes a one-beat frame in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        good_d  = 1'b0;
        if (sop_acc) begin
            cnt_d   = CNT_ONE;
            state_d = RUN;
            if (state_q == RUN) begin
                err_d = 1'b1;
            end
            if (eop_acc) begin
                state_d = IDLE;
                if (FRAME_PIXELS == 1) begin
                    good_d = !err_d;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (state_q == RUN && acc) begin
            cnt_d = cnt_inc;
            if (eop_acc) begin
                state_d = IDLE;
                if (cnt_inc == LEN_GOOD) begin
                    good_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (cnt_inc == LEN_OVER) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            use_flag    <= 1'b0;
            freq_flag   <= '0;
            in_frame    <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            cnt_q     <= cnt_d;
            in_frame  <= (state_d == RUN);
            frame_err <= err_d;
            if (good_d) begin
                frame_count <= frame_count + 8'd1;
            end
            if (sop_acc) begin
                use_flag <= enable_req;
                // A disabled filter forces level 0; hysteresis keeps tracking.
                if (!enable_req) begin
                    freq_flag <= '0;
                end else if (commit_ok) begin
                    freq_flag <= commit_level;
                end
            end
        end
    end

endmodule

// File: tb/tb_inversion_scheduler.sv
module tb_inversion_scheduler;

    localparam int FP   = 16;
    localparam int CW   = 5;
    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable_req;
    logic [1:0] freq_req;
    logic       sop_in, eop_in, valid_in, ready_in;
    logic       use_flag;
    logic [1:0] freq_flag;
    logic       in_frame;
    logic       frame_err;
    logic [7:0] frame_count;

    int checks = 0;
    int errors = 0;

    inversion_scheduler #(
        .HOLD_FRAMES  (HOLD),
        .FRAME_PIXELS (FP),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_req  (enable_req),
        .freq_req    (freq_req),
        .sop_in      (sop_in),
        .eop_in      (eop_in),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .use_flag    (use_flag),
        .freq_flag   (freq_flag),
        .in_frame    (in_frame),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Frame-level view: open/closed flag, beats seen in the open frame, and
    // the history of levels requested at frame starts. A level commits when
    // the last HOLD requests were identical.
    bit         m_open;
    int         m_len;
    logic       m_use;
    logic [1:0] m_freq;
    logic       m_err;
    logic [7:0] m_fc;
    int         hist[$];

    function automatic void model_reset();
        m_open = 0; m_len = 0; m_use = 0; m_freq = 0; m_err = 0; m_fc = 0;
        hist.delete();
    endfunction

    function automatic void model_close();
        m_open = 0;
        if (m_len == FP) m_fc = m_fc + 8'd1;
        else m_err = 1;
    endfunction

    function automatic void model_step(bit rst, bit v, bit r, bit s, bit e,
                                       bit en, logic [1:0] fr);
        bit same;
        if (rst) begin
            model_reset();
            return;
        end
        m_err = 0;
        if (!(v && r)) return;
        if (s) begin
            hist.push_back(int'(fr));
            if (hist.size() > HOLD) void'(hist.pop_front());
            same = (hist.size() == HOLD);
            foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
            m_use = en;
            if (!en) m_freq = 0;
            else if (same) m_freq = fr;
            if (m_open) m_err = 1;
            m_open = 1;
            m_len  = 1;
            if (e) model_close();
        end else if (m_open) begin
            m_len++;
            if (e) model_close();
            else if (m_len == FP + 1) begin
                m_err  = 1;
                m_open = 0;
            end
        end
    endfunction

    function automatic logic [12:0] exp_vec();
        return {m_use, m_freq, m_open, m_err, m_fc};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {use_flag, freq_flag, in_frame, frame_err, frame_count};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input bit r, input bit s, input bit e);
        @(negedge clk);
        valid_in = v; ready_in = r; sop_in = s; eop_in = e;
        @(posedge clk);
        model_step(reset, v, r, s, e, enable_req, freq_req);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; valid_in = 0; ready_in = 0; sop_in = 0; eop_in = 0;
        @(posedge clk);
        model_step(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), 13'd0);
        end
    endtask

    task automatic test_clean_frames();
        do_reset();
        enable_req = 1; freq_req = 2'd2;
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < FP; b++) begin
                drive(1, 1, b == 0, b == FP - 1);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL clean f%0d b%0d: got %h expected %h", f, b, dut_vec(), exp_vec());
                end
                if (b == 0) begin
                    checks++;
                    if (use_flag !== 1'b1 || freq_flag !== ((f >= 2) ? 2'd2 : 2'd0)) begin
                        errors++;
                        $display("FAIL clean_sop_commit f%0d: got use=%b freq=%0d", f, use_flag, freq_flag);
                    end
                end
            end
            checks++;
            if (frame_count !== 8'(f + 1) || in_frame !== 1'b0) begin
                errors++;
                $display("FAIL clean_count f%0d: got %0d in_frame=%b expected %0d", f, frame_count, in_frame, f + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int b, guard;
        bit r;
        enable_req = 1; freq_req = 2'd1;
        for (int f = 0; f < 3; f++) begin
            // sop/eop offered but never accepted
            drive(1, 0, 1, 1);
            drive(0, 1, 1, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bp_unaccepted f%0d: got %h expected %h", f, dut_vec(), exp_vec());
            end
            b = 0; guard = 0;
            while (b < FP && guard < 400) begin
                r = 1'($urandom_range(0, 1));
                drive(1, r, b == 0, b == FP - 1);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL bp f%0d b%0d: got %h expected %h", f, b, dut_vec(), exp_vec());
                end
                if (r) b++;
                guard++;
            end
            checks++;
            if (b != FP) begin
                errors++;
                $display("FAIL bp_budget f%0d: got %0d beats expected %0d", f, b, FP);
            end
        end
    endtask

    task automatic test_flicker();
        do_reset();
        enable_req = 1;
        for (int f = 0; f < 7; f++) begin
            freq_req = (f < 4) ? ((f % 2 == 0) ? 2'd3 : 2'd0) : 2'd3;
            for (int b = 0; b < FP; b++) begin
                drive(1, 1, b == 0, b == FP - 1);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL flicker f%0d b%0d: got %h expected %h", f, b, dut_vec(), exp_vec());
                end
                if (b == 0) begin
                    checks++;
                    if (freq_flag !== ((f == 6) ? 2'd3 : 2'd0)) begin
                        errors++;
                        $display("FAIL flicker_level f%0d: got %0d", f, freq_flag);
                    end
                end
            end
        end
    endtask

    task automatic test_short_frame();
        logic [7:0] fc0;
        fc0 = frame_count;
        for (int b = 0; b < 10; b++) drive(1, 1, b == 0, b == 9);
        checks++;
        if (frame_err !== 1'b1 || in_frame !== 1'b0 || frame_count !== fc0) begin
            errors++;
            $display("FAIL short_eop: got err=%b in_frame=%b count=%0d expected 1 0 %0d", frame_err, in_frame, frame_count, fc0);
        end
        drive(0, 0, 0, 0);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse_width: got %b expected 0", frame_err);
        end
        for (int b = 0; b < FP; b++) drive(1, 1, b == 0, b == FP - 1);
        checks++;
        if (frame_count !== fc0 + 8'd1 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL short_recover: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_missing_and_overlong();
        for (int b = 0; b < 8; b++) drive(1, 1, b == 0, 0);
        drive(1, 1, 1, 0);
        checks++;
        if (frame_err !== 1'b1 || in_frame !== 1'b1) begin
            errors++;
            $display("FAIL missing_eop: got err=%b in_frame=%b expected 1 1", frame_err, in_frame);
        end
        // restarted frame: FP-1 more beats with eop at the end is good
        for (int b = 1; b < FP; b++) drive(1, 1, 0, b == FP - 1);
        checks++;
        if (dut_vec() !== exp_vec() || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL missing_restart: got %h expected %h", dut_vec(), exp_vec());
        end
        for (int b = 0; b <= FP; b++) drive(1, 1, b == 0, 0);
        checks++;
        if (frame_err !== 1'b1 || in_frame !== 1'b0) begin
            errors++;
            $display("FAIL overlong: got err=%b in_frame=%b expected 1 0", frame_err, in_frame);
        end
        for (int b = 0; b < 4; b++) drive(1, 1, 0, b == 3);
        checks++;
        if (dut_vec() !== exp_vec() || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL overlong_ignore: got %h expected %h", dut_vec(), exp_vec());
        end
        drive(1, 1, 1, 1);
        checks++;
        if (dut_vec() !== exp_vec() || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL one_beat_frame: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_enable_drop_and_reset();
        enable_req = 1; freq_req = 2'd1;
        for (int b = 0; b < FP; b++) drive(1, 1, b == 0, b == FP - 1);
        for (int b = 0; b < FP; b++) begin
            if (b == 5) enable_req = 0;
            drive(1, 1, b == 0, b == FP - 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL en_drop b%0d: got %h expected %h", b, dut_vec(), exp_vec());
            end
        end
        drive(1, 1, 1, 0);
        checks++;
        if (use_flag !== 1'b0 || freq_flag !== 2'd0) begin
            errors++;
            $display("FAIL en_drop_sop: got use=%b freq=%0d expected 0 0", use_flag, freq_flag);
        end
        enable_req = 1;
        for (int b = 0; b < 4; b++) drive(1, 1, b == 0, 0);
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        model_step(1, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (dut_vec() !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_frame: got %h expected 0", dut_vec());
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_random();
        int len;
        bit r;
        for (int f = 0; f < 40; f++) begin
            len = FP - 2 + int'($urandom_range(0, 4));
            enable_req = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) freq_req = 2'($urandom_range(0, 3));
            for (int b = 0; b < len; ) begin
                r = ($urandom_range(0, 3) != 0);
                drive($urandom_range(0, 7) != 0, r, b == 0, b == len - 1);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL random f%0d b%0d: got %h expected %h", f, b, dut_vec(), exp_vec());
                end
                if (valid_in && ready_in) b++;
            end
            drive(0, 1, 0, 0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1; enable_req = 0; freq_req = 0;
        sop_in = 0; eop_in = 0; valid_in = 0; ready_in = 0;
        model_reset();
        test_reset();
        test_clean_frames();
        test_backpressure();
        test_flicker();
        test_short_frame();
        test_missing_and_overlong();
        test_enable_drop_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
